data_mem_responder: RTL and testbench

- Responder end of the core's data-memory load/store request interface.
- Accepts one request at a time over a valid/ready request channel and inserts a programmable number of wait states.
- Performs a word read, or a byte-enabled write, on an internal word array.
- Returns the result over a valid/ready response channel. Used to exercise and later replace the combinational memory so the core can be made stall-aware.

---
 rtl/data_mem_responder.sv | 190 +++++++++++++++++++
 tb/tb_data_mem_responder.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : data_mem_responder
//  Brief    : Responder end of the core's data-memory load/store interface.
//             Accepts one request at a time over a valid/ready channel,
//             inserts WAIT_STATES wait cycles, performs a word read or a
//             byte-enabled write on an internal word array, and returns the
//             result over a valid/ready response channel.
//  Revision : 1.0 - initial release
// ============================================================================
module data_mem_responder #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_STATES = 2
) (
  input  logic                  clk,
  input  logic                  reset_ni,
  // request channel
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_write_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [31:0]           req_wdata_i,
  input  logic [3:0]            req_be_i,
  // response channel
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [31:0]           rsp_rdata_o,
  output logic                  rsp_error_o
);

  // Word index carried by the byte address, and the width needed to index
  // the physical array.
  localparam int         c_idx_w     = ADDR_WIDTH - 2;
  localparam int         c_mem_aw    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  // Counter preload; the legal range 0..15 fits the 4-bit counter.
  localparam logic [3:0] c_wait_init = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                  state_q;
  logic [3:0]              cnt_q;

  // Request captured at the handshake edge
  logic                    write_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [31:0]             wdata_q;
  logic [3:0]              be_q;

  // Registered response payload
  logic [31:0]             rdata_q;
  logic                    error_q;

  // Word storage; deliberately not reset
  logic [31:0]             mem_q [DEPTH_WORDS];

  // Access operands: straight from the request pins when the access happens
  // on the handshake edge (zero wait states), otherwise from the latched copy.
  logic                    acc_write;
  logic [ADDR_WIDTH-1:0]   acc_addr;
  logic [31:0]             acc_wdata;
  logic [3:0]              acc_be;
  logic [c_idx_w-1:0]      acc_idx;
  logic [c_mem_aw-1:0]     mem_idx;
  logic                    do_access;
  logic                    error_d;
  logic [31:0]             rdata_d;
  logic [31:0]             mem_word;
  logic [31:0]             mem_wdata_d;
  logic                    mem_we;

  // Handshake-side outputs decode the registered state only
  assign req_ready_o = (state_q == S_IDLE);
  assign rsp_valid_o = (state_q == S_RESP);
  assign rsp_rdata_o = rdata_q;
  assign rsp_error_o = error_q;

  // Select the operands of the access happening at the coming edge
  always_comb begin
    acc_write = write_q;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    acc_be    = be_q;
    if (state_q == S_IDLE) begin
      acc_write = req_write_i;
      acc_addr  = req_addr_i;
      acc_wdata = req_wdata_i;
      acc_be    = req_be_i;
    end
  end

  assign acc_idx = acc_addr[ADDR_WIDTH-1:2];
  assign mem_idx = c_mem_aw'(acc_idx);

  // The access fires on the handshake edge for zero wait states, otherwise on
  // the last WAIT edge (counter at 1; 0 treated alike as a safe fallback).
  assign do_access = ((state_q == S_IDLE) && req_valid_i && (WAIT_STATES == 0)) ||
                     ((state_q == S_WAIT) && (cnt_q <= 4'd1));

  // Decode error, read data and the merged store word for the pending access
  always_comb begin
    error_d     = (acc_addr[1:0] != 2'b00) ||
                  (32'(acc_idx) >= 32'(DEPTH_WORDS));
    mem_word    = mem_q[mem_idx];
    rdata_d     = 32'h0;
    mem_wdata_d = mem_word;
    for (int b = 0; b < 4; b++) begin
      if (acc_be[b]) begin
        mem_wdata_d[8*b +: 8] = acc_wdata[8*b +: 8];
      end
    end
    if (!error_d && !acc_write) begin
      rdata_d = mem_word;
    end
  end

  // Stores commit only when in range and aligned; a store caught in reset
  // never reaches this edge because the FSM is already back in IDLE.
  assign mem_we = do_access && acc_write && !error_d;

  // Array write port (gated by reset so nothing commits while held in reset)
  always_ff @(posedge clk) begin
    if (reset_ni && mem_we) begin
      mem_q[mem_idx] <= mem_wdata_d;
    end
  end

  // Control FSM: request capture, wait-state countdown and response hold
  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      be_q    <= 4'h0;
      rdata_q <= 32'h0;
      error_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid_i) begin
            write_q <= req_write_i;
            addr_q  <= req_addr_i;
            wdata_q <= req_wdata_i;
            be_q    <= req_be_i;
            if (WAIT_STATES == 0) begin
              state_q <= S_RESP;
              rdata_q <= rdata_d;
              error_q <= error_d;
            end else begin
              state_q <= S_WAIT;
              cnt_q   <= c_wait_init;
            end
          end
        end
        S_WAIT: begin
          if (cnt_q <= 4'd1) begin
            state_q <= S_RESP;
            cnt_q   <= 4'd0;
            rdata_q <= rdata_d;
            error_q <= error_d;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_RESP: begin
          // Payload is held until the initiator takes it
          if (rsp_ready_i) begin
            state_q <= S_IDLE;
            rdata_q <= 32'h0;
            error_q <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          cnt_q   <= 4'd0;
          rdata_q <= 32'h0;
          error_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_data_mem_responder
//  Brief    : Directed self-checking bench. Instance A uses the default build
//             (2 wait states, 64 words); instance B is a zero-wait-state build
//             with 63 words so the upper word index is out of range.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;

  logic        clk;
  logic        rst_n;

  logic        a_req_valid, a_req_ready, a_req_write;
  logic [7:0]  a_req_addr;
  logic [31:0] a_req_wdata;
  logic [3:0]  a_req_be;
  logic        a_rsp_valid, a_rsp_ready, a_rsp_error;
  logic [31:0] a_rsp_rdata;

  logic        b_req_valid, b_req_ready, b_req_write;
  logic [7:0]  b_req_addr;
  logic [31:0] b_req_wdata;
  logic [3:0]  b_req_be;
  logic        b_rsp_valid, b_rsp_ready, b_rsp_error;
  logic [31:0] b_rsp_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  data_mem_responder #(.ADDR_WIDTH(8), .DEPTH_WORDS(64), .WAIT_STATES(2)) u_ws2 (
    .clk(clk), .reset_ni(rst_n),
    .req_valid_i(a_req_valid), .req_ready_o(a_req_ready), .req_write_i(a_req_write),
    .req_addr_i(a_req_addr), .req_wdata_i(a_req_wdata), .req_be_i(a_req_be),
    .rsp_valid_o(a_rsp_valid), .rsp_ready_i(a_rsp_ready),
    .rsp_rdata_o(a_rsp_rdata), .rsp_error_o(a_rsp_error)
  );

  data_mem_responder #(.ADDR_WIDTH(8), .DEPTH_WORDS(63), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .reset_ni(rst_n),
    .req_valid_i(b_req_valid), .req_ready_o(b_req_ready), .req_write_i(b_req_write),
    .req_addr_i(b_req_addr), .req_wdata_i(b_req_wdata), .req_be_i(b_req_be),
    .rsp_valid_o(b_rsp_valid), .rsp_ready_i(b_rsp_ready),
    .rsp_rdata_o(b_rsp_rdata), .rsp_error_o(b_rsp_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction on instance A. lat counts edges from the handshake
  // edge (inclusive) to the first cycle rsp_valid is seen; -1 on timeout.
  // The request pins are scrambled after the handshake to expose any
  // dependence on live inputs.
  task automatic req_a(input logic w, input logic [7:0] addr, input logic [31:0] d,
                       input logic [3:0] be, output int lat,
                       output logic [31:0] rd, output logic er);
    int n;
    a_req_write = w; a_req_addr = addr; a_req_wdata = d; a_req_be = be;
    a_req_valid = 1'b1;
    n = 0;
    while (a_req_ready !== 1'b1 && n < 20) begin tick(); n++; end
    tick();
    a_req_valid = 1'b0;
    a_req_write = ~w; a_req_addr = addr ^ 8'h44; a_req_wdata = ~d; a_req_be = ~be;
    lat = 1;
    while (a_rsp_valid !== 1'b1 && lat < 40) begin tick(); lat++; end
    if (a_rsp_valid !== 1'b1) lat = -1;
    rd = a_rsp_rdata;
    er = a_rsp_error;
    a_rsp_ready = 1'b1;
    tick();
    a_rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    n_checks++; if (a_req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_a_req_ready: got %b want 1", a_req_ready); end
    n_checks++; if (a_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_a_rsp_valid: got %b want 0", a_rsp_valid); end
    n_checks++; if (a_rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_a_rdata: got %h want 0", a_rsp_rdata); end
    n_checks++; if (a_rsp_error !== 1'b0) begin n_fail++; $display("FAIL reset_a_error: got %b want 0", a_rsp_error); end
    n_checks++; if (b_req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_b_req_ready: got %b want 1", b_req_ready); end
    n_checks++; if (b_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_b_rsp_valid: got %b want 0", b_rsp_valid); end
    n_checks++; if (b_rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_b_rdata: got %h want 0", b_rsp_rdata); end
    n_checks++; if (b_rsp_error !== 1'b0) begin n_fail++; $display("FAIL reset_b_error: got %b want 0", b_rsp_error); end
    tick();
    rst_n = 1'b1;
    tick();
    n_checks++; if (a_req_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_ready: got %b want 1", a_req_ready); end
  endtask

  task automatic test_store_load();
    int lat; logic [31:0] rd; logic er;
    req_a(1'b1, 8'h10, 32'hDEADBEEF, 4'hF, lat, rd, er);
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL store_latency: got %0d want 3", lat); end
    n_checks++; if (er !== 1'b0) begin n_fail++; $display("FAIL store_error: got %b want 0", er); end
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL store_rdata: got %h want 0", rd); end
    req_a(1'b0, 8'h10, 32'h0, 4'h0, lat, rd, er);
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL load_latency: got %0d want 3", lat); end
    n_checks++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL load_rdata: got %h want deadbeef", rd); end
    n_checks++; if (er !== 1'b0) begin n_fail++; $display("FAIL load_error: got %b want 0", er); end
    n_checks++; if (a_req_ready !== 1'b1) begin n_fail++; $display("FAIL idle_after_rsp: got %b want 1", a_req_ready); end
  endtask

  task automatic test_byte_enables();
    int lat; logic [31:0] rd; logic er;
    req_a(1'b1, 8'h20, 32'h11223344, 4'hF, lat, rd, er);
    req_a(1'b1, 8'h20, 32'hAABBCCDD, 4'b0101, lat, rd, er);
    n_checks++; if (er !== 1'b0) begin n_fail++; $display("FAIL be_store_error: got %b want 0", er); end
    req_a(1'b0, 8'h20, 32'h0, 4'h0, lat, rd, er);
    n_checks++; if (rd !== 32'h11BB33DD) begin n_fail++; $display("FAIL be_0101_rdata: got %h want 11bb33dd", rd); end
    req_a(1'b1, 8'h20, 32'hFFFFFFFF, 4'b0000, lat, rd, er);
    n_checks++; if (er !== 1'b0) begin n_fail++; $display("FAIL be_0000_error: got %b want 0", er); end
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL be_0000_latency: got %0d want 3", lat); end
    req_a(1'b0, 8'h20, 32'h0, 4'h0, lat, rd, er);
    n_checks++; if (rd !== 32'h11BB33DD) begin n_fail++; $display("FAIL be_0000_rdata: got %h want 11bb33dd", rd); end
    req_a(1'b1, 8'h24, 32'hA1B2C3D4, 4'b1010, lat, rd, er);
    req_a(1'b1, 8'h24, 32'h00000000, 4'b0101, lat, rd, er);
    req_a(1'b0, 8'h24, 32'h0, 4'h0, lat, rd, er);
    n_checks++; if (rd !== 32'hA100C300) begin n_fail++; $display("FAIL be_pair_rdata: got %h want a100c300", rd); end
  endtask

  task automatic test_errors();
    int lat; logic [31:0] rd; logic er;
    req_a(1'b1, 8'h00, 32'h0BADCAFE, 4'hF, lat, rd, er);
    req_a(1'b0, 8'h13, 32'h0, 4'h0, lat, rd, er);
    n_checks++; if (er !== 1'b1) begin n_fail++; $display("FAIL misaligned_load_error: got %b want 1", er); end
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL misaligned_load_rdata: got %h want 0", rd); end
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL misaligned_load_latency: got %0d want 3", lat); end
    req_a(1'b1, 8'h02, 32'h12345678, 4'hF, lat, rd, er);
    n_checks++; if (er !== 1'b1) begin n_fail++; $display("FAIL misaligned_store_error: got %b want 1", er); end
    req_a(1'b0, 8'h00, 32'h0, 4'h0, lat, rd, er);
    n_checks++; if (rd !== 32'h0BADCAFE) begin n_fail++; $display("FAIL after_error_rdata: got %h want 0badcafe", rd); end
    n_checks++; if (er !== 1'b0) begin n_fail++; $display("FAIL after_error_error: got %b want 0", er); end
  endtask

  task automatic test_backpressure();
    int n; int lat; logic [31:0] rd; logic er;
    a_req_write = 1'b0; a_req_addr = 8'h10; a_req_wdata = 32'h0; a_req_be = 4'h0;
    a_req_valid = 1'b1;
    tick();
    // A second request (a store) stays offered while the response is stalled
    a_req_write = 1'b1; a_req_wdata = 32'h0; a_req_be = 4'hF;
    n = 0;
    while (a_rsp_valid !== 1'b1 && n < 20) begin tick(); n++; end
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (a_rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d]: got %b want 1", i, a_rsp_valid); end
      n_checks++; if (a_rsp_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL bp_rdata[%0d]: got %h want deadbeef", i, a_rsp_rdata); end
      n_checks++; if (a_rsp_error !== 1'b0) begin n_fail++; $display("FAIL bp_error[%0d]: got %b want 0", i, a_rsp_error); end
      n_checks++; if (a_req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_req_ready[%0d]: got %b want 0", i, a_req_ready); end
      tick();
    end
    a_req_valid = 1'b0;
    a_rsp_ready = 1'b1;
    tick();
    a_rsp_ready = 1'b0;
    n_checks++; if (a_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid: got %b want 0", a_rsp_valid); end
    n_checks++; if (a_req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b want 1", a_req_ready); end
    n_checks++; if (a_rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL bp_release_rdata: got %h want 0", a_rsp_rdata); end
    req_a(1'b0, 8'h10, 32'h0, 4'h0, lat, rd, er);
    n_checks++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL bp_no_second_accept: got %h want deadbeef", rd); end
  endtask

  task automatic test_ws0_back_to_back();
    logic        t_w  [7];
    logic [7:0]  t_a  [7];
    logic [31:0] t_d  [7];
    logic [3:0]  t_be [7];
    logic [31:0] t_rd [7];
    logic        t_er [7];
    t_w  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    t_a  = '{8'h04, 8'h04, 8'h04, 8'h04, 8'hFC, 8'hFC, 8'h04};
    t_d  = '{32'hCAFEF00D, 32'h0, 32'h00000077, 32'h0, 32'h12345678, 32'h0, 32'h0};
    t_be = '{4'hF, 4'h0, 4'b0001, 4'h0, 4'hF, 4'h0, 4'h0};
    t_rd = '{32'h0, 32'hCAFEF00D, 32'h0, 32'hCAFEF077, 32'h0, 32'h0, 32'hCAFEF077};
    t_er = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    n_checks++; if (b_req_ready !== 1'b1) begin n_fail++; $display("FAIL ws0_start_ready: got %b want 1", b_req_ready); end
    b_rsp_ready = 1'b1;
    b_req_valid = 1'b1;
    b_req_write = t_w[0]; b_req_addr = t_a[0]; b_req_wdata = t_d[0]; b_req_be = t_be[0];
    for (int i = 0; i < 7; i++) begin
      tick();
      n_checks++; if (b_rsp_valid !== 1'b1) begin n_fail++; $display("FAIL ws0_valid[%0d]: got %b want 1", i, b_rsp_valid); end
      n_checks++; if (b_req_ready !== 1'b0) begin n_fail++; $display("FAIL ws0_busy[%0d]: got %b want 0", i, b_req_ready); end
      n_checks++; if (b_rsp_rdata !== t_rd[i]) begin n_fail++; $display("FAIL ws0_rdata[%0d]: got %h want %h", i, b_rsp_rdata, t_rd[i]); end
      n_checks++; if (b_rsp_error !== t_er[i]) begin n_fail++; $display("FAIL ws0_error[%0d]: got %b want %b", i, b_rsp_error, t_er[i]); end
      if (i < 6) begin
        b_req_write = t_w[i+1]; b_req_addr = t_a[i+1]; b_req_wdata = t_d[i+1]; b_req_be = t_be[i+1];
      end else begin
        b_req_valid = 1'b0;
      end
      tick();
      n_checks++; if (b_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL ws0_gap_valid[%0d]: got %b want 0", i, b_rsp_valid); end
      n_checks++; if (b_req_ready !== 1'b1) begin n_fail++; $display("FAIL ws0_gap_ready[%0d]: got %b want 1", i, b_req_ready); end
    end
    b_rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid_op();
    int n; int lat; logic [31:0] rd; logic er;
    // Store caught in WAIT is discarded
    req_a(1'b1, 8'h08, 32'h01020304, 4'hF, lat, rd, er);
    a_req_write = 1'b1; a_req_addr = 8'h08; a_req_wdata = 32'h55AA55AA; a_req_be = 4'hF;
    a_req_valid = 1'b1;
    tick();
    a_req_valid = 1'b0;
    n_checks++; if (a_req_ready !== 1'b0) begin n_fail++; $display("FAIL mid_wait_busy: got %b want 0", a_req_ready); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++; if (a_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_wait_reset_valid: got %b want 0", a_rsp_valid); end
    n_checks++; if (a_req_ready !== 1'b1) begin n_fail++; $display("FAIL mid_wait_reset_ready: got %b want 1", a_req_ready); end
    tick();
    rst_n = 1'b1;
    tick();
    n_checks++; if (a_req_ready !== 1'b1) begin n_fail++; $display("FAIL mid_wait_release_ready: got %b want 1", a_req_ready); end
    n_checks++; if (a_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_wait_release_valid: got %b want 0", a_rsp_valid); end
    req_a(1'b0, 8'h08, 32'h0, 4'h0, lat, rd, er);
    n_checks++; if (rd !== 32'h01020304) begin n_fail++; $display("FAIL mid_wait_store_discarded: got %h want 01020304", rd); end
    // Store already in RESP is committed; the response is dropped
    req_a(1'b1, 8'h0C, 32'h0, 4'hF, lat, rd, er);
    a_req_write = 1'b1; a_req_addr = 8'h0C; a_req_wdata = 32'h0A0B0C0D; a_req_be = 4'hF;
    a_req_valid = 1'b1;
    tick();
    a_req_valid = 1'b0;
    n = 0;
    while (a_rsp_valid !== 1'b1 && n < 20) begin tick(); n++; end
    n_checks++; if (a_rsp_valid !== 1'b1) begin n_fail++; $display("FAIL resp_reached: got %b want 1", a_rsp_valid); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (a_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL resp_reset_valid: got %b want 0", a_rsp_valid); end
    tick();
    rst_n = 1'b1;
    tick();
    req_a(1'b0, 8'h0C, 32'h0, 4'h0, lat, rd, er);
    n_checks++; if (rd !== 32'h0A0B0C0D) begin n_fail++; $display("FAIL resp_store_committed: got %h want 0a0b0c0d", rd); end
  endtask

  initial begin
    rst_n = 1'b0;
    a_req_valid = 1'b0; a_req_write = 1'b0; a_req_addr = 8'h0; a_req_wdata = 32'h0;
    a_req_be = 4'h0; a_rsp_ready = 1'b0;
    b_req_valid = 1'b0; b_req_write = 1'b0; b_req_addr = 8'h0; b_req_wdata = 32'h0;
    b_req_be = 4'h0; b_rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_store_load();
    test_byte_enables();
    test_errors();
    test_backpressure();
    test_ws0_back_to_back();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
